// File: rtl/serial_to_parallel_if.sv
// Sample stream from the I2S deserializer toward capture/DMA logic.
// Valid/ready handshake; the head sample pops on o_valid && i_ready.
interface serial_to_parallel_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_channel;
  logic                  o_valid;
  logic                  i_ready;

  modport master (output o_data, output o_channel, output o_valid, input i_ready);
  modport slave  (input o_data, input o_channel, input o_valid, output i_ready);
endinterface

// File: rtl/serial_to_parallel.sv
// I2S receive deserializer: frames DATA_WIDTH-bit samples with the one-bit-delay
// rule, tags each with its channel and queues it in a first-word-fall-through FIFO.
module serial_to_parallel #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_bit_clk,
  input  logic                        i_reset,
  input  logic                        i_serial_data,
  input  logic                        i_lr_clk,
  serial_to_parallel_if.master        s_out,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_overflow,
  output logic                        o_frame_err
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CW-1:0] LAST     = CW'(DATA_WIDTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT} state_t;

  state_t                state;
  logic                  lr_d;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-2:0] shreg;
  logic                  chan;

  logic                  lr_edge;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic                  push;
  logic [DATA_WIDTH:0]   push_entry;

  assign lr_edge    = (i_lr_clk != lr_d);
  assign word_nxt   = {shreg, i_serial_data};
  // count == LAST means this edge carries the LSB, whether or not LR also moved
  assign push       = (state == ST_SHIFT) && (count == LAST);
  assign push_entry = {chan, word_nxt};

  always_ff @(posedge i_bit_clk) begin
    if (i_reset) begin
      lr_d        <= i_lr_clk;
      state       <= ST_IDLE;
      count       <= '0;
      shreg       <= '0;
      chan        <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      lr_d        <= i_lr_clk;
      o_frame_err <= 1'b0;
      case (state)
        ST_IDLE, ST_WAIT: begin
          if (lr_edge) begin
            state <= ST_SHIFT;
            count <= '0;
            chan  <= i_lr_clk;
          end
        end
        ST_SHIFT: begin
          if (lr_edge) begin
            // short slot: partial word is dropped, the new slot starts clean
            if (count != LAST) o_frame_err <= 1'b1;
            state <= ST_SHIFT;
            count <= '0;
            chan  <= i_lr_clk;
          end else begin
            shreg <= word_nxt[DATA_WIDTH-2:0];
            count <= count + CW'(1);
            if (count == LAST) state <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;
  logic                full, pop, wr_en;
  logic [DATA_WIDTH:0] head;

  assign full  = (level == FULL_LVL);
  assign pop   = s_out.o_valid && s_out.i_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge i_bit_clk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge i_bit_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && !wr_en) o_overflow <= 1'b1;
    end
  end

  assign head            = mem[rd_ptr];
  assign o_level         = level;
  assign s_out.o_valid   = (level != '0);
  assign s_out.o_data    = s_out.o_valid ? head[DATA_WIDTH-1:0] : '0;
  assign s_out.o_channel = s_out.o_valid ? head[DATA_WIDTH] : 1'b0;
endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed and randomized I2S slot streams checked against a slot-level queue model.
module tb_serial_to_parallel;
  localparam int W    = 32;
  localparam int D    = 4;
  localparam int MAXC = 2048;

  logic                 i_bit_clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_serial_data = 1'b0;
  logic                 i_lr_clk = 1'b1;
  logic [$clog2(D):0]   o_level;
  logic                 o_overflow, o_frame_err;

  serial_to_parallel_if #(.DATA_WIDTH(W)) bus ();

  serial_to_parallel #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .i_bit_clk     (i_bit_clk),
    .i_reset       (i_reset),
    .i_serial_data (i_serial_data),
    .i_lr_clk      (i_lr_clk),
    .s_out         (bus),
    .o_level       (o_level),
    .o_overflow    (o_overflow),
    .o_frame_err   (o_frame_err)
  );

  always #5 i_bit_clk = ~i_bit_clk;

  int errors = 0;
  int checks = 0;
  string scen = "init";

  // stream description: per-cycle LR and data, plus expected events keyed by cycle
  bit         lr_q[$];
  bit         dat_q[$];
  bit         ev_pv[MAXC];
  logic [W:0] ev_pd[MAXC];
  int         ev_ps[MAXC];
  bit         ev_fe[MAXC];
  int         ev_fs[MAXC];

  logic [W:0]   mq[$];
  bit           m_ov;
  logic [W-1:0] dut_popped[$];
  int           dut_ferr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s: got %0h expected %0h", scen, tag, got, exp);
    end
  endtask

  task automatic new_stream();
    lr_q.delete();
    dat_q.delete();
    dat_q.push_back(1'b0);
    for (int c = 0; c < MAXC; c++) begin
      ev_pv[c] = 1'b0;
      ev_fe[c] = 1'b0;
    end
    dut_popped.delete();
    dut_ferr = 0;
  endtask

  // A slot of len bits on channel ch; bits are val[len-1] down to val[0].
  task automatic add_slot(input bit ch, input int len, input logic [63:0] val);
    int s;
    s = lr_q.size();
    for (int i = 0; i < len; i++) begin
      lr_q.push_back(ch);
      dat_q.push_back(val[len-1-i]);
    end
    if (len >= W) begin
      ev_pv[s+W] = 1'b1;
      ev_pd[s+W] = {ch, val[len-1 -: W]};
      ev_ps[s+W] = s;
    end else begin
      ev_fe[s+len] = 1'b1;
      ev_fs[s+len] = s;
    end
  endtask

  task automatic tail(input int n);
    bit ch;
    ch = lr_q[lr_q.size()-1];
    for (int i = 0; i < n; i++) begin
      lr_q.push_back(ch);
      dat_q.push_back(1'b0);
    end
  endtask

  task automatic check_outputs(input bit fe_exp);
    logic [W:0] hd;
    hd = (mq.size() != 0) ? mq[0] : '0;
    check("valid",    bus.o_valid,   mq.size() != 0);
    check("data",     bus.o_data,    hd[W-1:0]);
    check("channel",  bus.o_channel, hd[W]);
    check("level",    o_level,       mq.size());
    check("overflow", o_overflow,    m_ov);
    check("frame_err", o_frame_err,  fe_exp);
  endtask

  task automatic do_reset(input bit idle_lr);
    i_reset       = 1'b1;
    i_lr_clk      = idle_lr;
    i_serial_data = 1'b0;
    bus.i_ready   = 1'b1;
    repeat (2) @(posedge i_bit_clk);
    #1;
    mq.delete();
    m_ov = 1'b0;
    check_outputs(1'b0);
    i_reset = 1'b0;
    @(posedge i_bit_clk);
    #1;
  endtask

  function automatic bit rdy(input int mode, input int p, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return t >= p;
      2:       return 1'($urandom_range(0, 1));
      default: return t == p;
    endcase
  endfunction

  task automatic play(input int mode, input int p, input int rst_at);
    bit pop, fe;
    for (int t = 0; t < lr_q.size(); t++) begin
      i_lr_clk      = lr_q[t];
      i_serial_data = dat_q[t];
      bus.i_ready   = rdy(mode, p, t);
      i_reset       = (t == rst_at);
      if (bus.o_valid && bus.i_ready && !i_reset) dut_popped.push_back(bus.o_data);
      @(posedge i_bit_clk);
      fe = 1'b0;
      if (t == rst_at) begin
        mq.delete();
        m_ov = 1'b0;
        // the slot in progress is abandoned; capture waits for the next LR edge
        for (int c = t; c < MAXC; c++) begin
          if (ev_pv[c] && ev_ps[c] <= t) ev_pv[c] = 1'b0;
          if (ev_fe[c] && ev_fs[c] <= t) ev_fe[c] = 1'b0;
        end
      end else begin
        pop = (mq.size() != 0) && bus.i_ready;
        if (pop) void'(mq.pop_front());
        if (ev_pv[t]) begin
          if (mq.size() < D) mq.push_back(ev_pd[t]);
          else m_ov = 1'b1;
        end
        fe = ev_fe[t];
      end
      #1;
      if (o_frame_err) dut_ferr++;
      check_outputs(fe);
    end
    i_reset = 1'b0;
  endtask

  initial begin
    bus.i_ready = 1'b1;

    scen = "stereo";
    do_reset(1'b1);
    new_stream();
    add_slot(1'b0, 32, 64'hA5A5_0001);
    add_slot(1'b1, 32, 64'h1234_5678);
    tail(4);
    play(0, 0, -1);
    check("npops", dut_popped.size(), 2);
    if (dut_popped.size() == 2) begin
      check("pop0", dut_popped[0], 32'hA5A5_0001);
      check("pop1", dut_popped[1], 32'h1234_5678);
    end
    check("ferr_cnt", dut_ferr, 0);

    scen = "backpressure";
    do_reset(1'b1);
    new_stream();
    for (int k = 1; k <= 6; k++) add_slot(1'((k - 1) % 2), 32, 64'(k));
    tail(12);
    play(1, 6 * 32 + 1, -1);
    check("npops", dut_popped.size(), 4);
    for (int k = 0; k < dut_popped.size() && k < 4; k++) check("pop_order", dut_popped[k], k + 1);
    check("ovf_sticky", o_overflow, 1);

    scen = "short_slot";
    do_reset(1'b1);
    new_stream();
    add_slot(1'b0, 20, 64'hABCDE);
    add_slot(1'b1, 32, 64'hDEAD_BEEF);
    tail(4);
    play(0, 0, -1);
    check("ferr_cnt", dut_ferr, 1);
    check("npops", dut_popped.size(), 1);
    if (dut_popped.size() == 1) check("pop0", dut_popped[0], 32'hDEAD_BEEF);

    scen = "long_slot";
    do_reset(1'b1);
    new_stream();
    add_slot(1'b0, 40, {24'h0, 32'hCAFE_F00D, 8'hFF});
    add_slot(1'b1, 32, 64'($urandom));
    tail(4);
    play(0, 0, -1);
    check("ferr_cnt", dut_ferr, 0);
    check("npops", dut_popped.size(), 2);
    if (dut_popped.size() >= 1) check("pop0", dut_popped[0], 32'hCAFE_F00D);

    scen = "full_pushpop";
    do_reset(1'b1);
    new_stream();
    for (int k = 0; k < 5; k++) add_slot(1'(k % 2), 32, 64'(11 + k));
    tail(4);
    play(3, 160, -1);
    check("level_end", o_level, 4);
    check("ovf_end", o_overflow, 0);
    check("npops", dut_popped.size(), 1);
    if (dut_popped.size() == 1) check("pop0", dut_popped[0], 11);

    scen = "mid_reset";
    do_reset(1'b1);
    new_stream();
    for (int k = 0; k < 4; k++) add_slot(1'(k % 2), 32, 64'(21 + k));
    tail(4);
    play(1, 100000, 80);
    check("level_end", o_level, 1);
    check("head_end", bus.o_data, 24);

    for (int it = 0; it < 3; it++) begin
      bit ch;
      int len, r;
      scen = $sformatf("random%0d", it);
      do_reset(1'b1);
      new_stream();
      ch = 1'b0;
      for (int k = 0; k < 12; k++) begin
        r = $urandom_range(0, 9);
        if (k == 11 || r < 6) len = 32;
        else if (r < 8)       len = $urandom_range(33, 40);
        else                  len = $urandom_range(8, 31);
        add_slot(ch, len, {$urandom, $urandom});
        ch = !ch;
      end
      tail(8);
      play(2, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

I2S receive deserializer, the receive-side counterpart of the team's I2S transmit serializer. It samples the serial data line and word-select (LR) clock on the bit clock and frames 32-bit samples using the I2S one-bit-delay rule. Each complete sample is tagged with its channel and queued in a small first-word-fall-through FIFO. The FIFO drains over a valid/ready stream toward the capture/DMA logic.

## Interface
- DATA_WIDTH, 32, sample width in bits (≥ 8)
- FIFO_DEPTH, 4, output queue entries (power of 2, ≥ 2)

- i_bit_clk  input  1  I2S bit clock; all logic runs on its rising edge
- i_reset  input  1  synchronous, active-high reset
- i_serial_data  input  1  I2S serial data, MSB first
- i_lr_clk  input  1  word select: 0 = left, 1 = right
- o_data  output  DATA_WIDTH  head-of-queue sample; 0 while queue empty
- o_channel  output  1  channel of o_data; 0 while queue empty
- o_valid  output  1  queue non-empty
- i_ready  input  1  consumer accepts head when o_valid && i_ready
- o_level  output  $clog2(FIFO_DEPTH)+1  entries queued
- o_overflow  output  1  sticky: a completed sample was dropped (queue full)
- o_frame_err  output  1  one-cycle pulse: LR changed before a full sample was captured

## Operation
- Reset: lr_d <= i_lr_clk, so there is no false edge. State = IDLE, bit count = 0, queue emptied, o_overflow = 0, o_frame_err = 0, o_valid = 0, o_level = 0, o_data = 0, o_channel = 0.
- Edge detect: an edge occurs at rising edge k when the sampled i_lr_clk != lr_d. lr_d updates every cycle.
- Bits of the new word are sampled at edges k+1 … k+DATA_WIDTH, MSB first. Channel = i_lr_clk sampled at edge k.
- States:
  - IDLE: discard data. On edge → SHIFT, count = 0, latch channel.
  - SHIFT: each edge without an LR edge, shift in the bit and count++.
    - When count reaches DATA_WIDTH, push {channel, word} and go to WAIT.
    - An LR edge with count == DATA_WIDTH-1 captures this bit as LSB, pushes, and restarts SHIFT for the new channel (normal back-to-back 32-bit slots).
    - An LR edge with count < DATA_WIDTH-1 discards the partial word, pulses o_frame_err, and restarts SHIFT.
  - WAIT: ignore extra bits of a long slot. On edge → SHIFT, no error.
- Queue: a push when full (without a same-cycle pop) drops the new sample and sets o_overflow. Push and pop in the same cycle when full: both succeed, level unchanged. Push and pop when empty: the word enters the queue, and o_valid goes high the next cycle.
- Pop only on o_valid && i_ready. Order is strictly FIFO, and pointers wrap modulo FIFO_DEPTH.
- Reset mid-word discards the partial word and all queued entries. Capture re-arms only after the next LR edge.

## Timing
- Latency: LSB sampled at edge N → o_valid/o_data/o_channel valid after edge N (first cycle following N) if the queue was empty.
- o_level updates on the same edge as the push/pop.
- o_frame_err is asserted for exactly the cycle following the offending LR edge.
- o_overflow is set on the cycle following the dropped push and holds until i_reset.
- Sustained rate: one sample per DATA_WIDTH bit clocks. Slots shorter than DATA_WIDTH cause errors; longer slots are truncated to the first DATA_WIDTH bits.

## Test plan
- Stereo frame, i_ready=1: left 0xA5A5_0001 (lr=0), then right 0x1234_5678 (lr=1), in back-to-back 32-bit slots → two pops in order: (ch0, 0xA5A50001), (ch1, 0x12345678). No errors; o_valid rises one cycle after each LSB edge.
- Backpressure: i_ready=0 for six words 1..6 → o_level saturates at 4 and o_overflow sets on the fifth. After i_ready=1, pops return 1,2,3,4 only.
- Short slot: LR toggles after 20 data bits → o_frame_err pulses once, no push. The following 32-bit slot 0xDEADBEEF is received correctly.
- Long slot: 40-bit slot carrying 0xCAFEF00D followed by 8 ones → sample 0xCAFEF00D. No error.
- Full queue with simultaneous pop and push → level stays 4, no overflow, order preserved.
- Assert i_reset at bit 15 of a word holding 2 queued entries → outputs return to reset values. No pushes occur until after the next LR edge; the first full slot after that is received correctly.
